// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register among N_REQ
//   requesters. A grant gives the winner one write. If the winner holds lock,
//   the grant stretches into a burst of up to MAX_HOLD consecutive writes.
//   Every release is followed by one idle cycle before the next tenure, and
//   the rotating priority pointer moves to the requester after the one that
//   just released.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   req    : per-requester write request
//   lock   : per-requester burst hold; only the current owner's bit matters
//   wdata  : packed write data, requester i in bits [i*WIDTH +: WIDTH]
//   gnt    : registered one-hot grant
//   ack    : registered one-hot write acknowledge (q shows that write)
//   q      : shared register contents
//   busy   : high while a grant is held
//   owner  : index of the current or most recent grantee
// -----------------------------------------------------------------------------
module rr_reg_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int WIDTH    = 8,
    parameter  int MAX_HOLD = 8,
    localparam int OWN_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [OWN_W-1:0]       owner
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t            state_r,    state_s;
    logic [OWN_W-1:0]  rr_ptr_r,   rr_ptr_s;
    logic [HC_W-1:0]   hold_cnt_r, hold_cnt_s;
    logic [N_REQ-1:0]  gnt_r,      gnt_s;
    logic [N_REQ-1:0]  ack_r,      ack_s;
    logic [WIDTH-1:0]  q_r,        q_s;
    logic [OWN_W-1:0]  owner_r,    owner_s;

    logic [OWN_W:0]    pick_s;      // {found, index}
    logic              win_found_s;
    logic [OWN_W-1:0]  win_idx_s;
    logic              keep_s;

    // Rotating search: first set request bit starting at ptr, wrapping around.
    function automatic logic [OWN_W:0] pick_winner(input logic [N_REQ-1:0] req_v,
                                                   input logic [OWN_W-1:0] ptr_v);
        logic             found;
        logic [OWN_W-1:0] idx;
        int               pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = (int'(ptr_v) + i) % N_REQ;
            if (!found && req_v[OWN_W'(pos)]) begin
                found = 1'b1;
                idx   = OWN_W'(pos);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign pick_s      = pick_winner(req, rr_ptr_r);
    assign win_found_s = pick_s[OWN_W];
    assign win_idx_s   = pick_s[OWN_W-1:0];

    // The owner keeps the register only while it still requests, holds lock
    // and has not used up its burst allowance.
    assign keep_s = req[owner_r] & lock[owner_r] & (hold_cnt_r < HC_W'(MAX_HOLD));

    // Next-state and next-output logic for the IDLE/OWNED arbiter.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        ack_s      = ack_r;
        q_s        = q_r;
        owner_s    = owner_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    gnt_s      = N_REQ'(1) << win_idx_s;
                    ack_s      = N_REQ'(1) << win_idx_s;
                    q_s        = wdata[int'(win_idx_s)*WIDTH +: WIDTH];
                    owner_s    = win_idx_s;
                    hold_cnt_s = HC_W'(1);
                    state_s    = OWNED;
                end else begin
                    gnt_s = '0;
                    ack_s = '0;
                end
            end
            OWNED: begin
                if (keep_s) begin
                    q_s        = wdata[int'(owner_r)*WIDTH +: WIDTH];
                    ack_s      = gnt_r;
                    hold_cnt_s = hold_cnt_r + HC_W'(1);
                end else begin
                    // Release: the just-served requester drops to lowest priority.
                    gnt_s      = '0;
                    ack_s      = '0;
                    hold_cnt_s = '0;
                    state_s    = IDLE;
                    rr_ptr_s   = OWN_W'((int'(owner_r) + 1) % N_REQ);
                end
            end
            default: begin
                gnt_s      = '0;
                ack_s      = '0;
                hold_cnt_s = '0;
                state_s    = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
            gnt_r      <= '0;
            ack_r      <= '0;
            q_r        <= '0;
            owner_r    <= '0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            ack_r      <= ack_s;
            q_r        <= q_s;
            owner_r    <= owner_s;
        end
    end

    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign q     = q_r;
    assign busy  = |gnt_r;
    assign owner = owner_r;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_reg_arbiter
//   Scoreboard bench for rr_reg_arbiter. The stimulus thread advances a
//   behavioural model at each rising edge and queues the writes it expects.
//   A separate monitor checks at each falling edge. It pops a queued write
//   whenever the DUT raises ack, and it compares gnt/busy/q/owner with the
//   model every cycle.
// -----------------------------------------------------------------------------
module tb_rr_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   lock  = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [1:0]     owner;

    rr_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           idx;
        logic [W-1:0] data;
    } wr_t;

    wr_t sb[$];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int tb_cycle  = 0;

    // Reference model state.
    int           m_ptr   = 0;
    int           m_owner = 0;
    int           m_cnt   = 0;
    bit           m_busy  = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [N-1:0] exp_gnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cycle);
    endtask

    function automatic logic [W-1:0] data_of(input int i);
        return wdata[i*W +: W];
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_busy  = 1'b0;
        m_q     = '0;
        exp_gnt = '0;
        sb.delete();
    endtask

    // One rising edge of the arbiter, computed from the rules: rotating
    // search when free, burst continuation or release when owned.
    task automatic model_step();
        int w;
        tb_cycle++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_cnt   = 1;
                m_q     = data_of(w);
                exp_gnt = N'(1) << w;
                sb.push_back('{tb_cycle, w, m_q});
            end else begin
                exp_gnt = '0;
            end
        end else if (req[m_owner] && lock[m_owner] && m_cnt < MH) begin
            m_cnt++;
            m_q = data_of(m_owner);
            sb.push_back('{tb_cycle, m_owner, m_q});
        end else begin
            m_busy  = 1'b0;
            exp_gnt = '0;
            m_ptr   = (m_owner + 1) % N;
            m_cnt   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic rst_pulse();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_q",     32'(q),     32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: scoreboard pop on ack, plus per-cycle state comparison.
    initial begin
        wr_t r;
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    r = sb.pop_front();
                    chk("ack_cycle",  32'(tb_cycle), 32'(r.cyc));
                    chk("ack_onehot", 32'(ack),      32'(N'(1) << r.idx));
                    chk("ack_q",      32'(q),        32'(r.data));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= tb_cycle) begin
                r = sb.pop_front();
                chk("ack_missing", 32'(ack), 32'(N'(1) << r.idx));
            end
            chk("gnt",   32'(gnt),   32'(exp_gnt));
            chk("busy",  32'(busy),  32'(|exp_gnt));
            chk("q",     32'(q),     32'(m_q));
            chk("owner", 32'(owner), 32'(m_owner));
        end
    end

    initial begin
        logic [W-1:0] third;
        int           acks;

        // Power-on reset.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // 1: burst in progress, asynchronous reset, requester 0 wins afterwards.
        req  = 4'hF;
        lock = 4'hF;
        rand_data();
        step();
        step();
        step();
        rst_pulse();
        rand_data();
        step();
        chk("t1_first_gnt", 32'(gnt), 32'h1);
        req  = '0;
        lock = '0;
        step();
        step();

        // 2: single unlocked write from requester 2.
        rand_data();
        wdata[2*W +: W] = 8'hA5;
        req = 4'b0100;
        step();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_q",   32'(q),   32'hA5);
        req = '0;
        step();
        chk("t2_bubble", 32'(gnt), 32'h0);

        // 3: rotation, pointer now at 3.
        req = 4'hF;
        rand_data();
        step();
        chk("t3_first", 32'(gnt), 32'h8);
        for (int i = 0; i < 9; i++) begin
            rand_data();
            step();
        end
        req = '0;
        step();
        step();

        // 4: burst cap by requester 1.
        req  = 4'b0010;
        lock = 4'b0010;
        acks = 0;
        for (int i = 0; i < MH + 1; i++) begin
            rand_data();
            step();
            if (ack[1]) acks++;
        end
        chk("t4_acks",    32'(acks), 32'(MH));
        chk("t4_release", 32'(gnt),  32'h0);
        req  = 4'b0101;
        lock = '0;
        step();
        chk("t4_ptr2", 32'(gnt), 32'h4);
        req = '0;
        step();
        step();

        // 5: early release of a locked burst by requester 3.
        req  = 4'b1001;
        lock = 4'b1000;
        third = '0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            third = wdata[3*W +: W];
            step();
            chk("t5_ack", 32'(ack), 32'h8);
        end
        req = 4'b0001;
        rand_data();
        step();
        chk("t5_gnt_clear", 32'(gnt), 32'h0);
        chk("t5_q_kept",    32'(q),   32'(third));
        step();
        chk("t5_next_win",  32'(gnt), 32'h1);
        req  = '0;
        lock = '0;
        step();
        step();

        // 6: others' activity ignored while requester 2 owns.
        req  = 4'b0100;
        lock = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            wdata[0 +: W] = W'($urandom);
            req[0]        = i[0];
            lock[0]       = ~i[0];
            step();
            chk("t6_gnt", 32'(gnt), 32'h4);
        end
        req  = '0;
        lock = '0;
        step();
        step();

        // 7: randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            req  = N'($urandom);
            lock = N'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                req[m_owner]  = 1'b1;
                lock[m_owner] = 1'b1;
            end
            rand_data();
            if ($urandom_range(0, 63) == 0) rst_pulse();
            else step();
        end

        req  = '0;
        lock = '0;
        step();
        step();
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
